// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if
//   Bundles the trigger/length inputs and the stretched-pulse status outputs
//   of pulse_stretcher.
//   master: drives trigger_in, pulse_len and holdoff_len, and observes the
//           outputs (trigger conditioning logic or a testbench).
//   slave : the stretcher itself.
//   Signals:
//     trigger_in   single-cycle trigger
//     pulse_len    output pulse length in clk cycles (CNT_W bits)
//     holdoff_len  dead time after each pulse in clk cycles (CNT_W bits)
//     pulse_out    stretched pulse
//     busy         high while a pulse or its hold-off is running
//     done         one-cycle strobe when the pulse ends
//     missed       one-cycle strobe for a trigger that was not accepted
interface pulse_stretcher_if #(
  parameter int CNT_W = 16
);
  logic             trigger_in;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] holdoff_len;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             missed;

  modport master (
    output trigger_in, pulse_len, holdoff_len,
    input  pulse_out, busy, done, missed
  );

  modport slave (
    input  trigger_in, pulse_len, holdoff_len,
    output pulse_out, busy, done, missed
  );
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns a single-cycle trigger into a clock-aligned pulse of pulse_len
//   cycles, followed by an optional hold-off of holdoff_len cycles during
//   which new triggers are rejected.
//   Ports:
//     clk    system clock, all logic on posedge
//     rst_n  asynchronous active-low reset
//     ps     pulse_stretcher_if.slave (trigger_in, pulse_len, holdoff_len in;
//            pulse_out, busy, done, missed out -- all outputs registered)
//   Optional feature:
//     PULSE_STRETCHER_RETRIGGER_EN -- when defined, a trigger during the
//     pulse (with pulse_len != 0) restarts the pulse length instead of being
//     flagged as missed.
//   CNT_W must match the CNT_W of the connected interface instance.
module pulse_stretcher #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  pulse_stretcher_if.slave  ps
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pulse_q;
  logic             busy_q;
  logic             done_q;
  logic             missed_q;

  logic len_ok;
  logic retrig;

  assign len_ok = (ps.pulse_len != ZERO);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  assign retrig = ps.trigger_in & len_ok;
`else
  assign retrig = 1'b0;
`endif

  // cnt holds "cycles remaining minus one" so the terminal edge is the one
  // that sees cnt==0; this makes pulse_out high for exactly pulse_len cycles
  // and keeps the counter from ever wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= ZERO;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      case (state)
        IDLE: begin
          // A zero-length request is silently dropped (not a miss).
          if (ps.trigger_in && len_ok) begin
            state   <= ACTIVE;
            cnt     <= ps.pulse_len - ONE;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (retrig) begin
            cnt <= ps.pulse_len - ONE;
          end else begin
            missed_q <= ps.trigger_in;
            if (cnt != ZERO) begin
              cnt <= cnt - ONE;
            end else begin
              pulse_q <= 1'b0;
              done_q  <= 1'b1;
              // Hold-off length is sampled here, at the end of the pulse.
              if (ps.holdoff_len == ZERO) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                state <= HOLDOFF;
                cnt   <= ps.holdoff_len - ONE;
              end
            end
          end
        end
        HOLDOFF: begin
          missed_q <= ps.trigger_in;
          if (cnt != ZERO) begin
            cnt <= cnt - ONE;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= ZERO;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ps.pulse_out = pulse_q;
  assign ps.busy      = busy_q;
  assign ps.done      = done_q;
  assign ps.missed    = missed_q;

endmodule
